// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: CRC-32 constants, the byte-wise reflected CRC update,
// and the FCS-append state encoding.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY  = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT  = 32'hFFFFFFFF;
  localparam int          ETH_MIN_LEN = 60;

  typedef enum logic [1:0] {
    ST_DATA,
    ST_PAD,
    ST_FCS
  } fcs_state_t;

  // Reflected CRC-32: the byte enters at the LSB end and is shifted out LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_fcs_append.sv
// TX-path stage: forwards a MAC frame unchanged, zero-pads short frames to MIN_LEN,
// then appends the 4-byte CRC-32 FCS least-significant byte first.
module eth_fcs_append
  import eth_pkg::*;
#(
  parameter int MIN_LEN = ETH_MIN_LEN,
  parameter bit PAD_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready
);

  localparam int            CW      = $clog2(MIN_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MIN_LEN);

  fcs_state_t    r_state;
  fcs_state_t    w_state_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_crc;
  logic [31:0]   r_fcs;
  logic [1:0]    r_fidx;

  logic          w_xfer;
  logic [7:0]    w_crc_in;
  logic [31:0]   w_crc_next;
  logic [CW-1:0] w_cnt_inc;
  logic          w_short;
  logic          w_pad_done;

  // Derived from state and inputs directly so the output logic below never feeds itself.
  assign w_xfer     = out_ready && ((r_state != ST_DATA) || in_valid);
  assign w_crc_in   = (r_state == ST_PAD) ? 8'h00 : in_data;
  assign w_crc_next = crc32_byte(r_crc, w_crc_in);
  assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_short    = PAD_EN && (w_cnt_inc < CNT_MAX);
  assign w_pad_done = (w_cnt_inc == CNT_MAX);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_DATA;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output gets a default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    out_data     = in_data;
    out_valid    = in_valid;
    in_ready     = out_ready;
    out_last     = 1'b0;
    unique case (r_state)
      ST_DATA: begin
        if (w_xfer && in_last) begin
          w_state_next = w_short ? ST_PAD : ST_FCS;
        end
      end
      ST_PAD: begin
        in_ready  = 1'b0;
        out_data  = 8'h00;
        out_valid = 1'b1;
        if (w_xfer && w_pad_done) begin
          w_state_next = ST_FCS;
        end
      end
      ST_FCS: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        out_data  = r_fcs[{r_fidx, 3'b000} +: 8];
        out_last  = (r_fidx == 2'd3);
        if (w_xfer && (r_fidx == 2'd3)) begin
          w_state_next = ST_DATA;
        end
      end
      default: begin
        w_state_next = ST_DATA;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_crc  <= CRC32_INIT;
      r_fcs  <= '0;
      r_fidx <= '0;
    end else if (w_xfer) begin
      unique case (r_state)
        ST_DATA, ST_PAD: begin
          r_crc <= w_crc_next;
          r_cnt <= w_cnt_inc;
          if (w_state_next == ST_FCS) begin
            r_fcs <= ~w_crc_next;
          end
        end
        ST_FCS: begin
          // fidx wraps 3 -> 0 on its own, ready for the next frame.
          r_fidx <= r_fidx + 2'd1;
          if (r_fidx == 2'd3) begin
            r_cnt <= '0;
            r_crc <= CRC32_INIT;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_fcs_append.sv
// Self-checking bench for eth_fcs_append: constant vector table on a no-pad instance,
// plus scoreboarded frame traffic on a padding instance against a bit-serial CRC model.
module tb_eth_fcs_append;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [7:0] in_data, out_data;
  logic       in_valid, in_last, in_ready, out_valid, out_last, out_ready;

  logic [7:0] np_in_data, np_out_data;
  logic       np_in_valid, np_in_last, np_in_ready, np_out_valid, np_out_last, np_out_ready;

  eth_fcs_append #(.MIN_LEN(60), .PAD_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
  );

  eth_fcs_append #(.MIN_LEN(60), .PAD_EN(1'b0)) dut_np (
    .clk(clk), .rst(rst),
    .in_data(np_in_data), .in_valid(np_in_valid), .in_last(np_in_last), .in_ready(np_in_ready),
    .out_data(np_out_data), .out_valid(np_out_valid), .out_last(np_out_last),
    .out_ready(np_out_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [8:0] exp_q[$];  // {last, data}

  function automatic logic [31:0] model_crc(input logic [7:0] m[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (m[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ m[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  function automatic void push_expected(input logic [7:0] f[$]);
    logic [7:0]  m[$];
    logic [31:0] c;
    m = f;
    while (m.size() < 60) m.push_back(8'h00);
    c = model_crc(m);
    foreach (m[i]) exp_q.push_back({1'b0, m[i]});
    for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), c[8*k +: 8]});
  endfunction

  // ---------------- sink: out_ready driver + scoreboard ----------------
  int rdy_mode = 2;  // 0: always ready, 1: random 50%, 2: never ready

  initial begin
    logic       prev_stall;
    logic [7:0] prev_d;
    logic       prev_l;
    logic [8:0] e;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_l     = 1'b0;
    out_ready  = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      #4;
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("held output during stall", 32'({out_valid, out_last, out_data}),
                              32'({1'b1, prev_l, prev_d}));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra output byte: got %h, expected no byte", out_data);
          end else begin
            e = exp_q.pop_front();
            check("output byte {last,data}", 32'({out_last, out_data}), 32'(e));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_d     = out_data;
        prev_l     = out_last;
      end
    end
  end

  // ---------------- source ----------------
  task automatic send_frame(input logic [7:0] f[$], input bit do_last, output int first_wait);
    int w;
    first_wait = 0;
    for (int i = 0; i < f.size(); i++) begin
      in_valid = 1'b1;
      in_data  = f[i];
      in_last  = do_last && (i == f.size() - 1);
      w = 0;
      #4;
      while (!in_ready) begin
        @(negedge clk);
        #4;
        w++;
        if (w > 20000) begin
          $display("FAIL source timeout: in_ready got 0, expected 1 within 20000 cycles");
          $fatal(1, "source stalled");
        end
      end
      if (i == 0) first_wait = w;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // ---------------- vector table for the no-pad instance ----------------
  typedef struct {
    logic [7:0] d;
    logic       v, l, r;
    logic [7:0] ed;
    logic       ev, el, eir;
  } vec_t;

  vec_t tbl[$];

  function automatic void add_vec(input logic [7:0] d, input logic v, l, r,
                                  input logic [7:0] ed, input logic ev, el, eir);
    vec_t t;
    t.d = d; t.v = v; t.l = l; t.r = r;
    t.ed = ed; t.ev = ev; t.el = el; t.eir = eir;
    tbl.push_back(t);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f[$];
    logic [7:0] g[$];
    int         w;
    int         len;
    int         budget;

    rst = 1'b0;
    in_data = 8'hC3; in_valid = 1'b0; in_last = 1'b0;
    np_in_data = 8'h00; np_in_valid = 1'b0; np_in_last = 1'b0; np_out_ready = 1'b0;

    // Reset-state outputs
    rdy_mode = 2;
    @(negedge clk); #2;
    check("reset out_valid/out_last", 32'({out_valid, out_last}), 32'(2'b00));
    check("reset out_data passthrough", 32'(out_data), 32'(8'hC3));
    check("reset in_ready follows out_ready=0", 32'(in_ready), 32'(1'b0));
    rdy_mode = 0;
    @(negedge clk); #2;
    check("reset in_ready follows out_ready=1", 32'(in_ready), 32'(1'b1));
    @(negedge clk);
    rst = 1'b1;

    // Test 1: PAD_EN=0, "123456789" -> CRC 0xCBF43926, stalls, back-to-back next byte
    add_vec(8'h5A, 0, 0, 1,  8'h5A, 0, 0, 1);
    add_vec(8'h5A, 0, 0, 0,  8'h5A, 0, 0, 0);
    add_vec(8'h31, 1, 0, 1,  8'h31, 1, 0, 1);
    add_vec(8'h32, 1, 0, 1,  8'h32, 1, 0, 1);
    add_vec(8'h33, 1, 0, 1,  8'h33, 1, 0, 1);
    add_vec(8'h34, 1, 0, 0,  8'h34, 1, 0, 0);
    add_vec(8'h34, 1, 0, 1,  8'h34, 1, 0, 1);
    add_vec(8'h35, 1, 0, 1,  8'h35, 1, 0, 1);
    add_vec(8'h36, 1, 0, 1,  8'h36, 1, 0, 1);
    add_vec(8'h37, 1, 0, 1,  8'h37, 1, 0, 1);
    add_vec(8'h38, 1, 0, 1,  8'h38, 1, 0, 1);
    add_vec(8'h39, 1, 1, 1,  8'h39, 1, 0, 1);
    add_vec(8'h77, 1, 0, 1,  8'h26, 1, 0, 0);
    add_vec(8'h77, 1, 0, 0,  8'h39, 1, 0, 0);
    add_vec(8'h77, 1, 0, 1,  8'h39, 1, 0, 0);
    add_vec(8'h77, 1, 0, 1,  8'hF4, 1, 0, 0);
    add_vec(8'h77, 1, 0, 1,  8'hCB, 1, 1, 0);
    add_vec(8'h77, 1, 0, 0,  8'h77, 1, 0, 0);
    add_vec(8'h77, 0, 0, 1,  8'h77, 0, 0, 1);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      np_in_data = tbl[i].d; np_in_valid = tbl[i].v; np_in_last = tbl[i].l;
      np_out_ready = tbl[i].r;
      #2;
      check($sformatf("nopad vec %0d {data,valid,last,in_ready}", i),
            32'({np_out_data, np_out_valid, np_out_last, np_in_ready}),
            32'({tbl[i].ed, tbl[i].ev, tbl[i].el, tbl[i].eir}));
    end
    @(negedge clk);
    np_in_valid = 1'b0;

    // Test 2: 1-byte frame, padded to 60
    f = {8'hAA};
    push_expected(f);
    send_frame(f, 1'b1, w);

    // Test 3: exactly MIN_LEN bytes, no pad
    f = {};
    for (int i = 0; i < 60; i++) f.push_back(8'(i));
    push_expected(f);
    send_frame(f, 1'b1, w);

    // Test 5: back-to-back frames; frame 2 waits through 55 pad + 4 FCS transfers
    f = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    g = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    push_expected(f);
    push_expected(g);
    send_frame(f, 1'b1, w);
    send_frame(g, 1'b1, w);
    check("frame 2 first-byte stall cycles", 32'(w), 32'(59));

    // Test 4: random frames with 50% out_ready
    rdy_mode = 1;
    for (int n = 0; n < 100; n++) begin
      len = (n % 25 == 0) ? int'($urandom_range(1, 1514)) : int'($urandom_range(1, 160));
      f = {};
      for (int i = 0; i < len; i++) f.push_back(8'($urandom));
      push_expected(f);
      send_frame(f, 1'b1, w);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Drain before the reset test
    budget = 0;
    while (exp_q.size() != 0 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    check("scoreboard drained before reset test", 32'(exp_q.size()), 32'(0));

    // Test 6: reset during byte 20, then a clean 64-byte frame
    rdy_mode = 0;
    f = {};
    for (int i = 0; i < 20; i++) begin
      f.push_back(8'($urandom));
      exp_q.push_back({1'b0, f[i]});
    end
    send_frame(f, 1'b0, w);
    in_valid = 1'b0;
    in_data  = 8'h9E;
    rst      = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      check("mid-frame reset {valid,last,in_ready}", 32'({out_valid, out_last, in_ready}),
            32'(3'b001));
      @(negedge clk);
    end
    rst = 1'b1;
    f = {};
    for (int i = 0; i < 64; i++) f.push_back(8'($urandom));
    push_expected(f);
    send_frame(f, 1'b1, w);

    budget = 0;
    while (exp_q.size() != 0 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    check("scoreboard drained at end", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
